// File: rtl/multicycle_rcpu.sv
// Multi-cycle R-format CPU: FETCH/DECODE/EXEC/WB over a req/valid instruction port,
// with an idle-time register preload port, a halt opcode and a per-instruction retire trace.
module multicycle_rcpu #(
  parameter int              DATA_W   = 32,
  parameter int              REG_AW   = 5,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [REG_AW-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              retire,
  output logic [PC_W-1:0]   ret_pc,
  output logic              ret_we,
  output logic [REG_AW-1:0] ret_rd,
  output logic [DATA_W-1:0] ret_data,
  output logic              halted,
  output logic              illegal
);

  localparam int NREGS = 2 ** REG_AW;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t            state, next_state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out;
  logic              skip;
  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              wb_we;

  assign opcode = ir[31:26];
  assign rs     = ir[21 +: REG_AW];
  assign rt     = ir[16 +: REG_AW];
  assign rd     = ir[11 +: REG_AW];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02: funct_legal = 1'b1;
      default:                                                funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                              input logic [4:0] sh, input logic [5:0] fn);
    alu_f = '0;
    case (fn)
      6'h20: alu_f = x + y;
      6'h22: alu_f = x - y;
      6'h24: alu_f = x & y;
      6'h25: alu_f = x | y;
      6'h27: alu_f = ~(x | y);
      6'h2A: alu_f = {{(DATA_W-1){1'b0}}, ($signed(x) < $signed(y))};
      6'h00: if (int'(sh) < DATA_W) alu_f = y << sh;
      6'h02: if (int'(sh) < DATA_W) alu_f = y >> sh;
      default: alu_f = '0;
    endcase
  endfunction

  // Skipped (non-zero opcode) and illegal-funct instructions still retire, without a write.
  assign wb_we     = !skip && funct_legal(funct) && (rd != '0);
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  if (imem_valid) next_state = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT)  next_state = S_HALT;
        else if (opcode != '0)  next_state = S_WB;
        else                    next_state = S_EXEC;
      end
      S_EXEC:   next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: the register file is cleared on reset, so it stays in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      skip     <= 1'b0;
      retire   <= 1'b0;
      ret_pc   <= '0;
      ret_we   <= 1'b0;
      ret_rd   <= '0;
      ret_data <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE:   if (cfg_we) regs[cfg_addr] <= cfg_data;
        S_FETCH:  if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          a    <= (rs == '0) ? '0 : regs[rs];
          b    <= (rt == '0) ? '0 : regs[rt];
          skip <= (opcode != '0);
          if (opcode == OP_HALT) halted <= 1'b1;
          else if (opcode != '0 || !funct_legal(funct)) illegal <= 1'b1;
        end
        S_EXEC:   alu_out <= alu_f(a, b, shamt, funct);
        S_WB: begin
          if (wb_we) regs[rd] <= alu_out;
          pc       <= pc + PC_W'(PC_STEP);
          retire   <= 1'b1;
          ret_pc   <= pc;
          ret_we   <= wb_we;
          ret_rd   <= rd;
          ret_data <= wb_we ? alu_out : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_rcpu.sv
// Bench for multicycle_rcpu: instruction-memory responder with per-fetch delays,
// retire scoreboard, table-driven ALU vectors and hand-written reset/halt/stall sequences.
module tb_multicycle_rcpu;

  logic        clk = 1'b0;
  logic        rst, start, cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        retire, ret_we, halted, illegal;
  logic [31:0] ret_pc, ret_data;
  logic [4:0]  ret_rd;

  multicycle_rcpu dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .retire(retire), .ret_pc(ret_pc), .ret_we(ret_we), .ret_rd(ret_rd), .ret_data(ret_data),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] HALT = {6'h3F, 26'h0};

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } ret_t;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  ret_t        exp_q[$];
  int          ret_cyc[$];
  logic [31:0] imem [0:63];
  int          delays [0:63];
  int          fetch_no = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    logic [4:0] rs5, rt5, rd5, sh5;
    rs5 = 5'(rs); rt5 = 5'(rt); rd5 = 5'(rd); sh5 = 5'(sh);
    return {6'h00, rs5, rt5, rd5, sh5, fn};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: answers each fetch after delays[n] wait cycles, checking the address holds.
  initial begin
    int          wcnt;
    logic [31:0] addr0;
    wcnt = 0;
    addr0 = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && !imem_valid) begin
        if (wcnt == 0) addr0 = imem_addr;
        else check("fetch_addr_stable", imem_addr, addr0);
        if (wcnt >= delays[fetch_no % 64]) begin
          imem_valid = 1'b1;
          imem_rdata = imem[imem_addr[7:2]];
          fetch_no++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        imem_valid = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Retire monitor: pops the scoreboard on every retire pulse.
  initial begin
    ret_t e;
    forever begin
      @(negedge clk);
      if (retire === 1'b1) begin
        ret_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: got ret_pc %h want no retire", ret_pc);
        end else begin
          e = exp_q.pop_front();
          check("ret_pc", ret_pc, e.pc);
          check("ret_we", 32'(ret_we), 32'(e.we));
          if (e.we) begin
            check("ret_rd", 32'(ret_rd), 32'(e.rd));
            check("ret_data", ret_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    repeat (2) @(negedge clk);
    fetch_no = 0;
    exp_q.delete();
    ret_cyc.delete();
    for (int i = 0; i < 64; i++) begin
      delays[i] = 0;
      imem[i] = HALT;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input int addr, input logic [31:0] data);
    cfg_we = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic load_add_sub();
    imem[0] = r_ins(1, 2, 3, 0, 6'h20);
    imem[1] = r_ins(2, 1, 4, 0, 6'h22);
    imem[2] = HALT;
    exp_q.push_back('{pc: 32'd0, we: 1'b1, rd: 5'd3, data: 32'd8});
    exp_q.push_back('{pc: 32'd4, we: 1'b1, rd: 5'd4, data: 32'hFFFF_FFFE});
  endtask

  vec_t vt [14];

  initial begin
    // Reset asserted in the middle of EXEC.
    do_reset();
    preload(1, 32'd5);
    imem[0] = r_ins(1, 1, 3, 0, 6'h20);
    run_start();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_retire", 32'(retire), 0);
    check("rst_ret_pc", ret_pc, 0);
    check("rst_ret_data", ret_data, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_req", 32'(imem_req), 0);
    check("idle_no_retire", 32'(ret_cyc.size()), 0);

    // add/sub, back-to-back retire spacing, then halt behaviour.
    do_reset();
    preload(1, 32'd5);
    preload(2, 32'd3);
    load_add_sub();
    run_start();
    wait_halt("halt_reached_1", 60);
    check("spacing_4", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("halt_imem_req", 32'(imem_req), 0);
    check("halt_pc", imem_addr, 32'd8);
    run_start();
    repeat (10) @(negedge clk);
    check("halt_no_retire", 32'(ret_cyc.size()), 32'd2);
    check("halt_pc_frozen", imem_addr, 32'd8);
    check("halt_stays", 32'(halted), 1);
    check("halt_req_after_start", 32'(imem_req), 0);
    check("no_illegal", 32'(illegal), 0);
    check("queue_empty_1", 32'(exp_q.size()), 0);

    // Same program with the second fetch stalled 3 cycles.
    do_reset();
    preload(1, 32'd5);
    preload(2, 32'd3);
    load_add_sub();
    delays[1] = 3;
    run_start();
    wait_halt("halt_reached_2", 80);
    check("spacing_7", 32'(ret_cyc[1] - ret_cyc[0]), 32'd7);
    check("queue_empty_2", 32'(exp_q.size()), 0);

    // Table-driven ALU, r0, illegal and skip vectors.
    vt[0]  = '{r_ins(2, 1, 5, 0, 6'h2A),  1'b1, 5'd5,  32'd1};
    vt[1]  = '{r_ins(0, 1, 6, 31, 6'h00), 1'b1, 5'd6,  32'h8000_0000};
    vt[2]  = '{r_ins(0, 6, 7, 31, 6'h02), 1'b1, 5'd7,  32'd1};
    vt[3]  = '{r_ins(0, 0, 8, 0, 6'h27),  1'b1, 5'd8,  32'hFFFF_FFFF};
    vt[4]  = '{r_ins(2, 1, 9, 0, 6'h20),  1'b1, 5'd9,  32'd0};
    vt[5]  = '{r_ins(1, 2, 10, 0, 6'h22), 1'b1, 5'd10, 32'd2};
    vt[6]  = '{r_ins(2, 1, 11, 0, 6'h24), 1'b1, 5'd11, 32'd1};
    vt[7]  = '{r_ins(6, 1, 12, 0, 6'h25), 1'b1, 5'd12, 32'h8000_0001};
    vt[8]  = '{r_ins(1, 2, 13, 0, 6'h2A), 1'b1, 5'd13, 32'd0};
    vt[9]  = '{r_ins(1, 1, 0, 0, 6'h20),  1'b0, 5'd0,  32'd0};
    vt[10] = '{r_ins(1, 1, 14, 0, 6'h3F), 1'b0, 5'd14, 32'd0};
    vt[11] = '{{6'h01, 26'h0000801},      1'b0, 5'd1,  32'd0};
    vt[12] = '{r_ins(0, 1, 15, 0, 6'h20), 1'b1, 5'd15, 32'd1};
    vt[13] = '{r_ins(14, 1, 16, 0, 6'h20), 1'b1, 5'd16, 32'd1};
    do_reset();
    preload(0, 32'd7);
    preload(1, 32'd1);
    for (int i = 0; i < 14; i++) begin
      imem[i] = vt[i].instr;
      exp_q.push_back('{pc: 32'(i * 4), we: vt[i].we, rd: vt[i].rd, data: vt[i].data});
    end
    cfg_we = 1'b1;
    cfg_addr = 5'd2;
    cfg_data = 32'hFFFF_FFFF;
    run_start();
    cfg_we = 1'b0;
    wait_halt("halt_reached_3", 200);
    check("illegal_sticky", 32'(illegal), 1);
    check("halt_pc_vec", imem_addr, 32'd56);
    check("retire_count_vec", 32'(ret_cyc.size()), 32'd14);
    check("queue_empty_3", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_rcpu.md
Name: multicycle_rcpu

Overview:
- Parametrised multi-cycle successor of the single-cycle R-format CPU.
- Fetches R-format instructions through a req/valid instruction-memory handshake and executes each in FETCH/DECODE/EXEC/WB phases.
- Holds its own PC and register file; registers are preloadable over a config port while idle.
- Adds a halt instruction and a per-instruction retire trace for the bench.

Parameters:
DATA_W, 32, datapath and register width (>=8).
REG_AW, 5, register address width; 2**REG_AW registers; instruction fields rs/rt/rd use their low REG_AW bits.
PC_W, 32, PC and instruction-address width.
RESET_PC, 0, PC value after reset.
PC_STEP, 4, PC increment per retired or skipped instruction.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  leave IDLE and begin fetching (sampled in IDLE only)
cfg_we  in  1  register preload strobe (honoured in IDLE only)
cfg_addr  in  REG_AW  preload register index
cfg_data  in  DATA_W  preload value
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_rdata  in  32  instruction word
imem_valid  in  1  instruction word valid
retire  out  1  one-cycle pulse per completed instruction
ret_pc  out  PC_W  PC of retired instruction
ret_we  out  1  retired instruction wrote a register
ret_rd  out  REG_AW  destination written
ret_data  out  DATA_W  value written
halted  out  1  core in HALT
illegal  out  1  sticky, set on unsupported opcode/funct

Behaviour:
- Reset (async, any state, mid-instruction included): state IDLE, PC=RESET_PC, all registers 0, IR 0, every output 0. Any in-flight fetch is abandoned.
- States:
  - IDLE: cfg_we writes reg[cfg_addr]=cfg_data, including index 0. start -> FETCH. cfg_we and start in the same cycle: the write lands and the state moves to FETCH.
  - FETCH: imem_req=1, imem_addr=PC, held stable until imem_valid. When imem_valid=1 in the same cycle, IR<=imem_rdata -> DECODE. imem_valid outside FETCH is ignored.
  - DECODE: A<=reg[rs], B<=reg[rt]. Register 0 reads as 0 regardless of content.
    - opcode 6'h3F -> HALT.
    - opcode != 0 -> WB as a skip: set illegal, no write.
    - otherwise -> EXEC.
  - EXEC: ALUOut<=f(A,B,shamt,funct); one cycle.
  - WB: if rd!=0 and funct is legal, reg[rd]<=ALUOut. PC<=PC+PC_STEP (wraps mod 2**PC_W). retire=1 with ret_* describing the instruction; ret_we=0 for rd==0, illegal or skip. -> FETCH.
  - HALT: halted=1, imem_req=0, PC frozen at the halt's address, start ignored. Exit only by rst. Halt does not pulse retire.
- Funct set (results truncated to DATA_W):
  - 20h add, 22h sub: two's-complement, wrap, no overflow trap.
  - 24h and, 25h or, 27h nor.
  - 2Ah slt: signed, result 0 or 1.
  - 00h sll, 02h srl: B shifted by the 5-bit shamt, zero-fill; shamt>=DATA_W gives 0.
  - Any other funct: illegal=1, no write, still retires.
- Latency: 4 cycles per instruction when imem_valid arrives in the first FETCH cycle; each wait cycle adds one.
- retire and halted are registered outputs.

Test Plan:
- Reset/idle: assert rst mid-EXEC -> next cycle all outputs 0, PC=0. Release; imem_req stays 0 until start.
- Preload r1=5, r2=3, start. Program add r3,r1,r2; sub r4,r2,r1 -> retire rd=3 data=8 at ret_pc=0; rd=4 data=FFFFFFFE at ret_pc=4; pulses 4 cycles apart.
- Preload r1=1, r2=FFFFFFFF. Run slt r5,r2,r1 -> 1; sll r6,r1,31 -> 80000000; srl r7,r6,31 -> 1; nor r8,r0,r0 -> FFFFFFFF.
- imem_valid delayed 3 cycles on the second fetch -> imem_addr=4 held steady; retire spacing 7 cycles; result unchanged.
- add r0,r1,r1 -> ret_we=0, r0 reads 0 later. Funct 3Fh -> illegal=1, retire, PC advances.
- Halt at PC=8 -> halted=1, imem_req=0, no further retire, start ignored; PC stays 8 until rst.
